// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - parametrised VGA timing generator with registered, blanked colour output
// Optional colour-bar source enabled by defining VGA_SYNC_GEN_TEST_PATTERN_EN.
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLOCK_DIV   = 2,
  parameter int COLOR_BITS  = 1,
  parameter int COORD_WIDTH = 10,
  parameter int SYNC_POL    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  input  logic [COLOR_BITS-1:0]  pixel_r,
  input  logic [COLOR_BITS-1:0]  pixel_g,
  input  logic [COLOR_BITS-1:0]  pixel_b,
  output logic [COORD_WIDTH-1:0] pixel_x,
  output logic [COORD_WIDTH-1:0] pixel_y,
  output logic                   pixel_valid,
  output logic                   pixel_tick,
  output logic                   frame_start,
  output logic                   vga_hsync,
  output logic                   vga_vsync,
  output logic [COLOR_BITS-1:0]  vga_r,
  output logic [COLOR_BITS-1:0]  vga_g,
  output logic [COLOR_BITS-1:0]  vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  localparam logic [DIV_W-1:0]       DIV_LAST = DIV_W'(CLOCK_DIV - 1);
  localparam logic [COORD_WIDTH-1:0] H_LAST   = COORD_WIDTH'(H_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] V_LAST   = COORD_WIDTH'(V_TOTAL - 1);
  localparam logic [COORD_WIDTH-1:0] H_VIS    = COORD_WIDTH'(H_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] V_VIS    = COORD_WIDTH'(V_VISIBLE);
  localparam logic [COORD_WIDTH-1:0] HS_BEG   = COORD_WIDTH'(H_VISIBLE + H_FRONT);
  localparam logic [COORD_WIDTH-1:0] HS_END   = COORD_WIDTH'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COORD_WIDTH-1:0] VS_BEG   = COORD_WIDTH'(V_VISIBLE + V_FRONT);
  localparam logic [COORD_WIDTH-1:0] VS_END   = COORD_WIDTH'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic                   SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0]       div_q, div_d;
  logic [COORD_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic                   hs_q, hs_d, vs_q, vs_d;
  logic [COLOR_BITS-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [COLOR_BITS-1:0]  src_r, src_g, src_b;
  logic                   h_sync_act, v_sync_act;

  assign pixel_x     = h_q;
  assign pixel_y     = v_q;
  assign pixel_valid = (h_q < H_VIS) && (v_q < V_VIS);
  // Gated by reset so no tick escapes while the counters are being held cleared.
  assign pixel_tick  = enable && !reset && (div_q == DIV_LAST);
  assign frame_start = pixel_tick && (h_q == '0) && (v_q == '0);
  assign h_sync_act  = (h_q >= HS_BEG) && (h_q < HS_END);
  assign v_sync_act  = (v_q >= VS_BEG) && (v_q < VS_END);

`ifdef VGA_SYNC_GEN_TEST_PATTERN_EN
  localparam logic [COORD_WIDTH+2:0] H_VIS_X = (COORD_WIDTH+3)'(H_VISIBLE);
  logic [COORD_WIDTH+2:0] h_x8;
  logic [2:0]             bar;
  assign h_x8  = {h_q, 3'b000};
  assign bar   = 3'(h_x8 / H_VIS_X);
  assign src_r = test_pattern ? {COLOR_BITS{bar[2]}} : pixel_r;
  assign src_g = test_pattern ? {COLOR_BITS{bar[1]}} : pixel_g;
  assign src_b = test_pattern ? {COLOR_BITS{bar[0]}} : pixel_b;
`else
  assign src_r = pixel_r;
  assign src_g = pixel_g;
  assign src_b = pixel_b;
`endif

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    hs_d  = hs_q;
    vs_d  = vs_q;
    r_d   = r_q;
    g_d   = g_q;
    b_d   = b_q;
    if (!enable) begin
      div_d = '0;
      hs_d  = ~SYNC_ACT;
      vs_d  = ~SYNC_ACT;
      r_d   = '0;
      g_d   = '0;
      b_d   = '0;
    end else if (pixel_tick) begin
      div_d = '0;
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + COORD_WIDTH'(1);
      end else begin
        h_d = h_q + COORD_WIDTH'(1);
      end
      // Pins carry the decode of the position being left, one tick behind the counters.
      hs_d = h_sync_act ? SYNC_ACT : ~SYNC_ACT;
      vs_d = v_sync_act ? SYNC_ACT : ~SYNC_ACT;
      r_d  = pixel_valid ? src_r : '0;
      g_d  = pixel_valid ? src_g : '0;
      b_d  = pixel_valid ? src_b : '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      hs_q  <= ~SYNC_ACT;
      vs_q  <= ~SYNC_ACT;
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
    end
  end

  assign vga_hsync = hs_q;
  assign vga_vsync = vs_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen, pixel-clock dividers 1 and 3
// Frame position model: a tick index within the 48-pixel frame, decoded by plain arithmetic.
module tb_vga_sync_gen;
  localparam int HV = 4, HF = 1, HS = 2, HB = 1;
  localparam int VV = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FT = HT * VT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en, pr, pg, pb;
  logic [9:0] x1, y1, x3, y3;
  logic val1, tk1, fs1, hs1, vs1, r1, g1, b1;
  logic val3, tk3, fs3, hs3, vs3, r3, g3, b3;

  vga_sync_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                 .CLOCK_DIV(1), .COLOR_BITS(1), .COORD_WIDTH(10), .SYNC_POL(0)) dut1 (
    .clock(clk), .reset(rst), .enable(en), .pixel_r(pr), .pixel_g(pg), .pixel_b(pb),
    .pixel_x(x1), .pixel_y(y1), .pixel_valid(val1), .pixel_tick(tk1), .frame_start(fs1),
    .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1));

  vga_sync_gen #(.H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
                 .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
                 .CLOCK_DIV(3), .COLOR_BITS(1), .COORD_WIDTH(10), .SYNC_POL(0)) dut3 (
    .clock(clk), .reset(rst), .enable(en), .pixel_r(pr), .pixel_g(pg), .pixel_b(pb),
    .pixel_x(x3), .pixel_y(y3), .pixel_valid(val3), .pixel_tick(tk3), .frame_start(fs3),
    .vga_hsync(hs3), .vga_vsync(vs3), .vga_r(r3), .vga_g(g3), .vga_b(b3));

  int n_chk = 0, n_fail = 0;
  int divv [2] = '{1, 3};
  int pos  [2];
  int run  [2];
  logic ehs [2], evs [2], er [2], eg [2], eb [2];
  logic cmp_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      pos[k] = 0; run[k] = 0;
      ehs[k] = 1'b1; evs[k] = 1'b1;
      er[k] = 1'b0; eg[k] = 1'b0; eb[k] = 1'b0;
    end
  endtask

  // Advance the model across one rising edge using the inputs held during it.
  task automatic model_step();
    int h, v;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        pos[k] = 0; run[k] = 0;
        ehs[k] = 1'b1; evs[k] = 1'b1;
        er[k] = 1'b0; eg[k] = 1'b0; eb[k] = 1'b0;
      end else if (!en) begin
        run[k] = 0;
        ehs[k] = 1'b1; evs[k] = 1'b1;
        er[k] = 1'b0; eg[k] = 1'b0; eb[k] = 1'b0;
      end else if (run[k] == divv[k] - 1) begin
        h = pos[k] % HT;
        v = pos[k] / HT;
        ehs[k] = !(h >= HV + HF && h < HV + HF + HS);
        evs[k] = !(v >= VV + VF && v < VV + VF + VS);
        er[k] = (h < HV && v < VV) ? pr : 1'b0;
        eg[k] = (h < HV && v < VV) ? pg : 1'b0;
        eb[k] = (h < HV && v < VV) ? pb : 1'b0;
        pos[k] = (pos[k] + 1) % FT;
        run[k] = 0;
      end else begin
        run[k] = run[k] + 1;
      end
    end
  endtask

  task automatic drive(input logic r_, input logic e_, input logic cr, input logic cg, input logic cb);
    rst = r_; en = e_; pr = cr; pg = cg; pb = cb;
    if (r_) model_reset();
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic cmp_inst(input int k, input logic [9:0] x, input logic [9:0] y,
                          input logic val, input logic tk, input logic fs,
                          input logic hs, input logic vs,
                          input logic r, input logic g, input logic b);
    int h, v;
    logic tk_e;
    h = pos[k] % HT;
    v = pos[k] / HT;
    tk_e = en && !rst && (run[k] == divv[k] - 1);
    check(k == 0 ? "x_div1" : "x_div3", int'(x), h);
    check(k == 0 ? "y_div1" : "y_div3", int'(y), v);
    check(k == 0 ? "valid_div1" : "valid_div3", int'(val), int'(h < HV && v < VV));
    check(k == 0 ? "tick_div1" : "tick_div3", int'(tk), int'(tk_e));
    check(k == 0 ? "fstart_div1" : "fstart_div3", int'(fs), int'(tk_e && pos[k] == 0));
    check(k == 0 ? "hsync_div1" : "hsync_div3", int'(hs), int'(ehs[k]));
    check(k == 0 ? "vsync_div1" : "vsync_div3", int'(vs), int'(evs[k]));
    check(k == 0 ? "rgb_div1" : "rgb_div3", int'({r, g, b}), int'({er[k], eg[k], eb[k]}));
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      cmp_inst(0, x1, y1, val1, tk1, fs1, hs1, vs1, r1, g1, b1);
      cmp_inst(1, x3, y3, val3, tk3, fs3, hs3, vs3, r3, g3, b3);
    end
  end

  initial begin
    int c_fs1, c_fs3, c_hs1, c_vs1, c_r1, c_tk3, c_hs3;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cmp_on = 1'b1;
    repeat (3) step();
    check("reset_x", int'(x1), 0);
    check("reset_hsync", int'(hs1), 1);
    check("reset_vsync", int'(vs3), 1);
    check("reset_color", int'({r1, g1, b1}), 0);
    check("reset_tick", int'(tk1), 0);

    // Free run with white input: count periodic events over two slow frames.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    repeat (100) step();
    c_fs1 = 0; c_fs3 = 0; c_hs1 = 0; c_vs1 = 0; c_r1 = 0; c_tk3 = 0; c_hs3 = 0;
    repeat (288) begin
      c_fs1 += int'(fs1); c_fs3 += int'(fs3); c_tk3 += int'(tk3);
      c_hs1 += int'(!hs1); c_vs1 += int'(!vs1); c_r1 += int'(r1); c_hs3 += int'(!hs3);
      step();
    end
    check("frames_div1_in_288", c_fs1, 6);
    check("frames_div3_in_288", c_fs3, 2);
    check("ticks_div3_in_288", c_tk3, 96);
    check("hsync_low_div1", c_hs1, 72);
    check("vsync_low_div1", c_vs1, 48);
    check("red_high_div1", c_r1, 72);
    check("hsync_low_div3", c_hs3, 72);

    // Drop enable at (2,1) for 10 clocks.
    for (int i = 0; i < 100 && pos[0] != HT + 2; i++) step();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) step();
    check("hold_x", int'(x1), 2);
    check("hold_y", int'(y1), 1);
    check("hold_syncs", int'({hs1, vs1}), 3);
    check("hold_color", int'({r1, g1, b1}), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check("resume_x", int'(x1), 3);
    check("resume_y", int'(y1), 1);

    // Reset pulsed at (5,4).
    for (int i = 0; i < 100 && pos[0] != 4 * HT + 5; i++) step();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("midreset_xy", int'({x1, y1}), 0);
    check("midreset_syncs", int'({hs1, vs1}), 3);
    check("midreset_color", int'({r1, g1, b1}), 0);
    check("midreset_fstart", int'(fs1), 0);
    step();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check("release_fstart", int'(fs1), 1);
    check("release_xy", int'({x1, y1}), 0);
    step();

    // Randomised enable, colour and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0,
            1'($urandom), 1'($urandom), 1'($urandom));
      step();
    end

    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
